// File: rtl/alu_pkg.sv
// Shared state encoding and default sizing for the ALU operand loader and its bench.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int W_DEFAULT        = 3;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int NUM_STAGES       = 5;

    // One-hot encoding so the state register can drive the LED bus directly.
    typedef enum logic [NUM_STAGES-1:0] {
        S_A   = 5'b00001,
        S_B   = 5'b00010,
        S_CIN = 5'b00100,
        S_OP  = 5'b01000,
        S_RUN = 5'b10000
    } state_t;

    function automatic state_t advance(input state_t s);
        case (s)
            S_A:     return S_B;
            S_B:     return S_CIN;
            S_CIN:   return S_OP;
            S_OP:    return S_RUN;
            default: return S_A;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability-count debouncer, rising-edge press pulse.
// Latency: press is high in the cycle after the 2 sync + DEBOUNCE_CYCLES stable-clock window.
// Backpressure: none; press is a one-shot pulse per debounced rising edge, release is silent.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync_q1;
    logic       sync_q2;
    logic       level_q;
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            level_q <= level;
            // Any clock where the input agrees with the accepted level restarts the window.
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Steps through a/b/c_in/opcode capture from switches on debounced button presses.
// Latency: field and state update on the edge after a press pulse; all outputs registered.
// Backpressure: none; clr beats next when both press in the same cycle.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int W               = W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          sw,
    input  logic                  btn_next,
    input  logic                  btn_clr,
    output logic [W-1:0]          a,
    output logic [W-1:0]          b,
    output logic [W-1:0]          c_in,
    output logic [W-1:0]          opcode,
    output logic                  valid,
    output logic [NUM_STAGES-1:0] stage
);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   a_nxt;
    logic [W-1:0]   b_nxt;
    logic [W-1:0]   c_in_nxt;
    logic [W-1:0]   opcode_nxt;
    logic           next_press;
    logic           clr_press;
    logic           next_level_unused;
    logic           clr_level_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_next),
        .level   (next_level_unused),
        .press   (next_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clr),
        .level   (clr_level_unused),
        .press   (clr_press)
    );

    always_comb begin
        state_nxt  = state;
        a_nxt      = a;
        b_nxt      = b;
        c_in_nxt   = c_in;
        opcode_nxt = opcode;
        if (clr_press) begin
            state_nxt  = S_A;
            a_nxt      = '0;
            b_nxt      = '0;
            c_in_nxt   = '0;
            opcode_nxt = '0;
        end else if (next_press) begin
            state_nxt = advance(state);
            case (state)
                S_A:     a_nxt      = sw;
                S_B:     b_nxt      = sw;
                S_CIN:   c_in_nxt   = sw;
                S_OP:    opcode_nxt = sw;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_A;
            a      <= '0;
            b      <= '0;
            c_in   <= '0;
            opcode <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_nxt;
            a      <= a_nxt;
            b      <= b_nxt;
            c_in   <= c_in_nxt;
            opcode <= opcode_nxt;
            valid  <= (state_nxt == S_RUN);
        end
    end

    assign stage = state;

endmodule
